// File: rtl/dram_pkg.sv
// Shared constants and FSM state encoding for the data-RAM access controller.
package dram_pkg;

  localparam int DRAM_ADDR_W = 12;
  localparam int DRAM_DATA_W = 8;
  localparam int DRAM_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2
  } dram_state_e;

endpackage

// File: rtl/dram_access_ctrl_watchdog.sv
// dram_watchdog: cycle counter that flags expiry after TIMEOUT_CYC enabled cycles.
// Present only when DRAM_CTRL_TIMEOUT_EN is defined.
`ifdef DRAM_CTRL_TIMEOUT_EN
module dram_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires during the TIMEOUT_CYC-th enabled cycle so the owner drops its request on the next edge.
  assign expire = en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/dram_access_ctrl.sv
// Initiator for the 4096x8 data RAM: single/burst reads and fills with done handshake.
// Optional watchdog on the RAM done pulse is enabled by defining DRAM_CTRL_TIMEOUT_EN.
module dram_access_ctrl
  import dram_pkg::*;
#(
  parameter int ADDR_W      = DRAM_ADDR_W,
  parameter int DATA_W      = DRAM_DATA_W,
  parameter int LEN_W       = DRAM_LEN_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_r_en,
  output logic              mem_w_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic [1:0]        dbg_state
);

  // Request side: req_ready is high only in IDLE and a request transfers on any edge where
  // req_valid && req_ready. Response side: rsp_valid is a single-cycle pulse with no back-pressure.

  dram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_last_q, rsp_last_d;
  logic              r_en_q, w_en_q;
  logic              req_ready_q, busy_q;
  logic              tmo;

`ifdef DRAM_CTRL_TIMEOUT_EN
  logic wd_expire;
  logic err_q;

  dram_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q != ACCESS),
    .en     (state_q == ACCESS),
    .expire (wd_expire)
  );

  assign tmo = wd_expire;

  // Sticky until the next request is accepted; a done arriving on the expiry cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && req_valid) begin
      err_q <= 1'b0;
    end else if (state_q == ACCESS && !mem_done && tmo) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC != 0);
  assign tmo        = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    remain_d    = remain_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          remain_d = (req_len == '0) ? LEN_W'(1) : req_len;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_done) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = we_q ? '0 : mem_rdata;
          remain_d    = remain_q - 1'b1;
          addr_d      = addr_q + 1'b1;
          if (remain_q == LEN_W'(1)) begin
            rsp_last_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = GAP;
          end
        end else if (tmo) begin
          // Abandon the rest of the burst with a single zero-data terminating beat.
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b1;
          remain_d    = '0;
          state_d     = IDLE;
        end
      end
      GAP: begin
        state_d = ACCESS;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      remain_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      r_en_q      <= 1'b0;
      w_en_q      <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      remain_q    <= remain_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      // Enables and status are registered from the next state so they align with it.
      r_en_q      <= (state_d == ACCESS) && !we_d;
      w_en_q      <= (state_d == ACCESS) && we_d;
      req_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_r_en  = r_en_q;
  assign mem_w_en  = w_en_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Randomized scoreboard bench for dram_access_ctrl with a RAM responder model.
// Exercises the DRAM_CTRL_TIMEOUT_EN watchdog when the bench is built with that macro.
module tb_dram_access_ctrl;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              busy;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_r_en;
  logic              mem_w_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  dram_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              first;
    int                start_cyc;
  } acc_t;

  acc_t              acc_q[$];
  logic [DATA_W:0]   exp_q[$];
  int                run_q[$];
  logic [DATA_W-1:0] ram     [0:4095];
  logic [DATA_W-1:0] ref_mem [0:4095];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fixed_lat = -1;
  int max_lat   = 3;
  bit hang      = 1'b0;
  bit spurious  = 1'b0;
  bit tmo_mode  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // RAM responder: picks a wait per access, pulses done, optionally injects stray done pulses.
  int wait_cnt = -1;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_done = 1'b0;
      wait_cnt = -1;
    end else begin
      mem_done = 1'b0;
      if ((mem_r_en || mem_w_en) && !hang) begin
        if (wait_cnt < 0) begin
          wait_cnt = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, max_lat);
          run_q.push_back(wait_cnt + 1);
        end
        if (wait_cnt == 0) begin
          mem_done  = 1'b1;
          mem_rdata = ram[mem_addr];
          if (mem_w_en) ram[mem_addr] = mem_wdata;
          wait_cnt  = -1;
        end else begin
          wait_cnt--;
        end
      end else if (!(mem_r_en || mem_w_en) && spurious && ($urandom_range(0, 1) == 1)) begin
        mem_done  = 1'b1;
        mem_rdata = DATA_W'($urandom);
      end
    end
  end

  // Monitor: checks RAM-side accesses and pops the response scoreboard.
  logic            mon_en;
  logic            prev_en  = 1'b0;
  logic            prev_hit = 1'b0;
  int              run_len  = 0;
  int              low_run  = 0;
  acc_t            cur;
  logic [DATA_W:0] e;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_en  = 1'b0;
      prev_hit = 1'b0;
      run_len  = 0;
      low_run  = 0;
    end else begin
      mon_en = mem_r_en || mem_w_en;
      if (!tmo_mode && (rsp_valid || prev_hit)) chk("rsp_timing", rsp_valid, prev_hit);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e[DATA_W-1:0]);
          chk("rsp_last", rsp_last, e[DATA_W]);
        end
      end
      if (mon_en) begin
        chk("en_exclusive", mem_r_en & mem_w_en, 0);
        if (!prev_en) begin
          if (acc_q.size() == 0) begin
            fail_now("access_unexpected");
          end else begin
            cur = acc_q.pop_front();
            chk("acc_addr", mem_addr, cur.addr);
            chk("acc_we", mem_w_en, cur.we);
            if (cur.we) chk("acc_wdata", mem_wdata, cur.wdata);
            if (cur.first) chk("start_latency", cyc, cur.start_cyc + 1);
            else chk("gap_len", low_run, 1);
          end
          run_len = 0;
        end else begin
          chk("addr_stable", mem_addr, cur.addr);
        end
        run_len++;
        low_run = 0;
      end else begin
        if (prev_en) begin
          if (run_q.size() == 0) fail_now("run_unexpected");
          else chk("enable_cycles", run_len, run_q.pop_front());
          low_run = 0;
        end
        low_run++;
      end
      prev_hit = mon_en && mem_done;
      prev_en  = mon_en;
    end
  end

  // Driver: the reference model expands each request into expected accesses and beats.
  task automatic issue_req(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] wdata,
                           input bit tmo_req);
    int                guard;
    int                n;
    acc_t              a;
    logic [DATA_W-1:0] d;
    guard = 0;
    while (!req_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      fail_now("req_ready_wait");
      return;
    end
    n = (len == '0) ? 1 : int'(len);
    if (tmo_req) n = 1;
    for (int i = 0; i < n; i++) begin
      a.addr      = addr + ADDR_W'(i);
      a.we        = we;
      a.wdata     = wdata;
      a.first     = (i == 0);
      a.start_cyc = cyc;
      acc_q.push_back(a);
      if (tmo_req) begin
        exp_q.push_back({1'b1, {DATA_W{1'b0}}});
      end else begin
        if (we) ref_mem[a.addr] = wdata;
        d = we ? {DATA_W{1'b0}} : ref_mem[a.addr];
        exp_q.push_back({(i == n - 1), d});
      end
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = ADDR_W'($urandom);
    req_len   = LEN_W'($urandom);
    req_wdata = DATA_W'($urandom);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(req_ready && exp_q.size() == 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) fail_now("idle_wait");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    logic [ADDR_W-1:0] ra;
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = DATA_W'($urandom);
      ref_mem[i] = ram[i];
    end
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_wdata = '0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_r_en", mem_r_en, 0);
    chk("rst_w_en", mem_w_en, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read, RAM answers on the third enable cycle.
    ram[12'h010]     = 8'hA5;
    ref_mem[12'h010] = 8'hA5;
    fixed_lat = 2;
    issue_req(1'b0, 12'h010, 8'd1, 8'h00, 1'b0);
    chk("busy_during_access", busy, 1);
    wait_idle();

    // Read burst across the top of the address space with a zero-wait RAM.
    fixed_lat = 0;
    issue_req(1'b0, 12'hFFE, 8'd4, 8'h00, 1'b0);
    wait_idle();

    // Fill burst of zeros, then read it back.
    issue_req(1'b1, 12'h100, 8'd3, 8'h00, 1'b0);
    wait_idle();
    issue_req(1'b0, 12'h0FF, 8'd5, 8'h00, 1'b0);
    wait_idle();

    // Length 0 is one beat; stray done pulses in IDLE and GAP must be ignored.
    spurious  = 1'b1;
    fixed_lat = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_ready_spurious", req_ready, 1);
    end
    issue_req(1'b0, 12'h222, 8'd0, 8'h00, 1'b0);
    wait_idle();
    issue_req(1'b1, 12'h223, 8'd3, 8'h5C, 1'b0);
    wait_idle();
    spurious = 1'b0;

    // Reset during the second beat of a five-beat read.
    fixed_lat = 1;
    issue_req(1'b0, 12'h200, 8'd5, 8'h00, 1'b0);
    begin
      int guard;
      guard = 0;
      while (acc_q.size() > 3 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) fail_now("second_beat_wait");
    end
    rst_n = 1'b0;
    #1;
    chk("abort_r_en", mem_r_en, 0);
    chk("abort_w_en", mem_w_en, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    acc_q.delete();
    exp_q.delete();
    run_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_no_rsp", rsp_valid, 0);

`ifdef DRAM_CTRL_TIMEOUT_EN
    // RAM never answers: enable held TMO cycles, one terminating beat, sticky err.
    hang     = 1'b1;
    tmo_mode = 1'b1;
    run_q.push_back(TMO);
    issue_req(1'b0, 12'h300, 8'd3, 8'h00, 1'b1);
    wait_idle();
    chk("tmo_err_set", err, 1);
    @(negedge clk);
    chk("tmo_err_sticky", err, 1);
    hang      = 1'b0;
    tmo_mode  = 1'b0;
    fixed_lat = 0;
    issue_req(1'b0, 12'h301, 8'd1, 8'h00, 1'b0);
    chk("tmo_err_clear", err, 0);
    wait_idle();
`endif

    // Randomized traffic, biased towards the address wrap.
    fixed_lat = -1;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = ($urandom_range(0, 3) == 0) ? ADDR_W'(12'hFFC + $urandom_range(0, 3)) : ADDR_W'($urandom);
      issue_req(1'($urandom), ra, LEN_W'($urandom_range(0, 6)), DATA_W'($urandom), 1'b0);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("acc_q_drained", acc_q.size(), 0);
    chk("final_busy", busy, 0);
`ifndef DRAM_CTRL_TIMEOUT_EN
    chk("err_tied_low", err, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
